// File: rtl/imm_gen_pkg.sv
// Shared types for the decode-path immediate generator: format codes,
// opcode constants and the buffered result entry.
package imm_gen_pkg;

  localparam int unsigned ENT_W = 64;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_U = 3'd1,
    FMT_S = 3'd2,
    FMT_R = 3'd3,
    FMT_B = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Fields are held at the widest XLEN; narrower builds use the low bits.
  typedef struct packed {
    logic [31:0]      instr;
    logic [ENT_W-1:0] pc;
    fmt_e             fmt;
    logic [ENT_W-1:0] imm;
    logic [ENT_W-1:0] target;
    logic             illegal;
  } entry_t;

endpackage

// File: rtl/imm_gen_if.sv
// Upstream/downstream handshake bundle for imm_gen_stage.
interface imm_gen_if #(
  parameter int unsigned XLEN = 64
);
  import imm_gen_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  fmt_e            out_fmt;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_fmt, out_imm,
           out_target, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_fmt, out_imm,
           out_target, out_illegal
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational format classification, immediate extraction and PC-relative
// target for one instruction.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output entry_t          ent
);

  logic [6:0]      op;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] target;
  fmt_e            fmt;
  logic            illegal;

  assign op = instr[6:0];

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));

  always_comb begin
    fmt     = FMT_R;
    illegal = 1'b0;
    case (op)
      OP_LOAD, OP_IMM, OP_IMM_32, OP_JALR, OP_FENCE, OP_SYSTEM: fmt = FMT_I;
      OP_LUI, OP_AUIPC:                                         fmt = FMT_U;
      OP_STORE:                                                 fmt = FMT_S;
      OP_OP, OP_32:                                             fmt = FMT_R;
      OP_BRANCH:                                                fmt = FMT_B;
      OP_JAL:                                                   fmt = FMT_J;
      default:                                                  illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) illegal = 1'b1;
    // W-form opcodes only exist on RV64.
    if (XLEN == 32 && (op == OP_IMM_32 || op == OP_32)) illegal = 1'b1;
    if (illegal) fmt = FMT_R;
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = imm_i;
      FMT_S:   imm = imm_s;
      FMT_B:   imm = imm_b;
      FMT_J:   imm = imm_j;
      FMT_U:   imm = imm_u;
      default: imm = '0;
    endcase
  end

  assign target = pc + imm;

  always_comb begin
    ent         = '0;
    ent.instr   = instr;
    ent.pc      = ENT_W'(pc);
    ent.fmt     = fmt;
    ent.imm     = ENT_W'(imm);
    ent.target  = ENT_W'(target);
    ent.illegal = illegal;
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decode on the input side, results held
// in a two-entry (main + skid) buffer so in_ready is purely registered.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  imm_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state, state_nxt;
  entry_t dec;
  entry_t main_q, skid_q;
  logic   accept, fire;
  logic   load_main, load_skid, move_skid;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (bus.in_instr),
    .pc    (bus.in_pc),
    .ent   (dec)
  );

  assign bus.out_valid = (state != ST_EMPTY);
  assign bus.in_ready  = (state != ST_FULL);
  assign accept        = bus.in_valid && bus.in_ready;
  assign fire          = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (fire) begin
          state_nxt = ST_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush discards everything, including a beat accepted this cycle.
    if (flush) begin
      state_nxt = ST_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)      main_q <= dec;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= dec;
    end
  end

  assign bus.out_instr   = main_q.instr;
  assign bus.out_pc      = main_q.pc[XLEN-1:0];
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_imm     = main_q.imm[XLEN-1:0];
  assign bus.out_target  = main_q.target[XLEN-1:0];
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage at XLEN=64 and XLEN=32.
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;

  imm_gen_if #(.XLEN(64)) b64 ();
  imm_gen_if #(.XLEN(32)) b32 ();

  imm_gen_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));
  imm_gen_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    fmt_e        fmt64;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic        ill64;
    fmt_e        fmt32;
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic        ill32;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive64(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    b64.in_valid = v;
    b64.in_instr = ins;
    b64.in_pc    = pc;
  endtask

  logic [31:0] beat[5];

  initial begin
    vecs[0]  = '{32'hFFF00093, 64'h100,  FMT_I, 64'hFFFFFFFFFFFFFFFF, 64'hFF,               1'b0, FMT_I, 32'hFFFFFFFF, 32'hFF,       1'b0};
    vecs[1]  = '{32'h800000B7, 64'h0,    FMT_U, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000, 1'b0, FMT_U, 32'h80000000, 32'h80000000, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 64'h1000, FMT_B, 64'hFFFFFFFFFFFFFFFC, 64'hFFC,              1'b0, FMT_B, 32'hFFFFFFFC, 32'hFFC,      1'b0};
    vecs[3]  = '{32'h0000006F, 64'h2000, FMT_J, 64'h0,                64'h2000,             1'b0, FMT_J, 32'h0,        32'h2000,     1'b0};
    vecs[4]  = '{32'h00000000, 64'h40,   FMT_R, 64'h0,                64'h40,               1'b1, FMT_R, 32'h0,        32'h40,       1'b1};
    vecs[5]  = '{32'h0000003B, 64'h80,   FMT_R, 64'h0,                64'h80,               1'b0, FMT_R, 32'h0,        32'h80,       1'b1};
    vecs[6]  = '{32'hFE20AC23, 64'h10,   FMT_S, 64'hFFFFFFFFFFFFFFF8, 64'h8,                1'b0, FMT_S, 32'hFFFFFFF8, 32'h8,        1'b0};
    vecs[7]  = '{32'h0050009B, 64'h0,    FMT_I, 64'h5,                64'h5,                1'b0, FMT_R, 32'h0,        32'h0,        1'b1};
    vecs[8]  = '{32'h0010006F, 64'h100,  FMT_J, 64'h800,              64'h900,              1'b0, FMT_J, 32'h800,      32'h900,      1'b0};
    vecs[9]  = '{32'h12345017, 64'h10,   FMT_U, 64'h12345000,         64'h12345010,         1'b0, FMT_U, 32'h12345000, 32'h12345010, 1'b0};
    vecs[10] = '{32'h0000007F, 64'h20,   FMT_R, 64'h0,                64'h20,               1'b1, FMT_R, 32'h0,        32'h20,       1'b1};

    drive64(1'b0, '0, '0);
    b64.out_ready = 1'b1;
    b32.in_valid  = 1'b0;
    b32.in_instr  = '0;
    b32.in_pc     = '0;
    b32.out_ready = 1'b1;

    #12;
    chk("rst_out_valid64", 64'(b64.out_valid), 64'd0);
    chk("rst_in_ready64",  64'(b64.in_ready),  64'd1);
    chk("rst_imm64",       b64.out_imm,        64'd0);
    chk("rst_out_valid32", 64'(b32.out_valid), 64'd0);
    chk("rst_in_ready32",  64'(b32.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, one beat at a time, applied to both widths.
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      drive64(1'b1, vecs[i].instr, vecs[i].pc);
      b32.in_valid = 1'b1;
      b32.in_instr = vecs[i].instr;
      b32.in_pc    = vecs[i].pc[31:0];
      @(posedge clk); #1;
      b64.in_valid = 1'b0;
      b32.in_valid = 1'b0;
      chk($sformatf("v%0d_valid64", i), 64'(b64.out_valid),   64'd1);
      chk($sformatf("v%0d_instr64", i), 64'(b64.out_instr),   64'(vecs[i].instr));
      chk($sformatf("v%0d_pc64", i),    b64.out_pc,           vecs[i].pc);
      chk($sformatf("v%0d_fmt64", i),   64'(b64.out_fmt),     64'(vecs[i].fmt64));
      chk($sformatf("v%0d_imm64", i),   b64.out_imm,          vecs[i].imm64);
      chk($sformatf("v%0d_tgt64", i),   b64.out_target,       vecs[i].tgt64);
      chk($sformatf("v%0d_ill64", i),   64'(b64.out_illegal), 64'(vecs[i].ill64));
      chk($sformatf("v%0d_valid32", i), 64'(b32.out_valid),   64'd1);
      chk($sformatf("v%0d_fmt32", i),   64'(b32.out_fmt),     64'(vecs[i].fmt32));
      chk($sformatf("v%0d_imm32", i),   64'(b32.out_imm),     64'(vecs[i].imm32));
      chk($sformatf("v%0d_tgt32", i),   64'(b32.out_target),  64'(vecs[i].tgt32));
      chk($sformatf("v%0d_ill32", i),   64'(b32.out_illegal), 64'(vecs[i].ill32));
    end
    @(posedge clk); #1;
    chk("drain_valid64", 64'(b64.out_valid), 64'd0);

    // Backpressure: three back-to-back beats against a stalled consumer.
    b64.out_ready = 1'b0;
    drive64(1'b1, 32'h00A00093, 64'h0);
    @(posedge clk); #1;
    chk("bp_ready_after1", 64'(b64.in_ready), 64'd1);
    drive64(1'b1, 32'h00B00093, 64'h4);
    @(posedge clk); #1;
    chk("bp_ready_after2", 64'(b64.in_ready),  64'd0);
    chk("bp_head_A",       64'(b64.out_instr), 64'h00A00093);
    drive64(1'b1, 32'h00C00093, 64'h8);
    @(posedge clk); #1;
    chk("bp_still_full", 64'(b64.in_ready),  64'd0);
    chk("bp_stable_A",   64'(b64.out_instr), 64'h00A00093);
    chk("bp_stable_imm", b64.out_imm,        64'hA);
    b64.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_head_B",     64'(b64.out_instr), 64'h00B00093);
    chk("bp_pc_B",       b64.out_pc,         64'h4);
    chk("bp_ready_back", 64'(b64.in_ready),  64'd1);
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    chk("bp_head_C",  64'(b64.out_instr), 64'h00C00093);
    chk("bp_valid_C", 64'(b64.out_valid), 64'd1);
    @(posedge clk); #1;
    chk("bp_empty", 64'(b64.out_valid), 64'd0);

    // Sustained streaming at one beat per cycle.
    for (int i = 0; i < 5; i++) beat[i] = 32'h00100093 + (32'(i) << 20);
    drive64(1'b1, beat[0], 64'h100);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("st%0d_valid", i), 64'(b64.out_valid), 64'd1);
      chk($sformatf("st%0d_instr", i), 64'(b64.out_instr), 64'(beat[i]));
      chk($sformatf("st%0d_imm", i),   b64.out_imm,        64'(i + 1));
      chk($sformatf("st%0d_ready", i), 64'(b64.in_ready),  64'd1);
      if (i < 4) drive64(1'b1, beat[i+1], 64'h100);
      else       b64.in_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("st_drain", 64'(b64.out_valid), 64'd0);

    // Flush from FULL with a beat offered in the flush cycle.
    b64.out_ready = 1'b0;
    drive64(1'b1, 32'h00100093, 64'h0);
    @(posedge clk); #1;
    drive64(1'b1, 32'h00200093, 64'h0);
    @(posedge clk); #1;
    chk("fl_full", 64'(b64.in_ready), 64'd0);
    drive64(1'b1, 32'h00D00093, 64'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    b64.in_valid = 1'b0;
    chk("fl_valid", 64'(b64.out_valid), 64'd0);
    chk("fl_ready", 64'(b64.in_ready),  64'd1);
    b64.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("fl_no_ghost", 64'(b64.out_valid), 64'd0);

    // Flush while EMPTY discards the beat accepted in that same cycle.
    drive64(1'b1, 32'h00E00093, 64'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    b64.in_valid = 1'b0;
    chk("fl_empty_drop", 64'(b64.out_valid), 64'd0);

    // Asynchronous reset mid-stream.
    b64.out_ready = 1'b0;
    drive64(1'b1, 32'hFFF00093, 64'h300);
    @(posedge clk); #1;
    drive64(1'b1, 32'h00100093, 64'h304);
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    chk("mr_pre_valid", 64'(b64.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(b64.out_valid), 64'd0);
    chk("mr_ready", 64'(b64.in_ready),  64'd1);
    chk("mr_imm",   b64.out_imm,        64'd0);
    chk("mr_instr", 64'(b64.out_instr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b64.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mr_after", 64'(b64.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
